// File: rtl/div_if.sv
// EX-stage <-> divide controller bus: operands, start/annul request and result/ready return.
// Handshake: start_i rises with operands held stable and stays high until ready_o=1 is seen; ready_o with result_o stays up while start_i is held; dropping start_i retires the result.
interface div_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic [1:0]           state_dbg;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o, state_dbg
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o, state_dbg
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU, WIDTH iterations plus a sign-fix edge.
// Optional DIV_EARLY_OUT_EN: finishes at once when |dividend| < |divisor|.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   partial_q;
  logic [CW-1:0]      counter_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               op1_neg;
  logic               op2_neg;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               accept;
  logic               div_zero;
  logic               early_out;
  logic               done;
  logic [WIDTH:0]     shifted;
  logic               no_borrow;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op1_neg  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign op2_neg  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign mag1     = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2     = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
  assign accept   = bus.start_i & ~bus.annul_i;
  assign div_zero = (bus.opdata2_i == '0);
  assign done     = (counter_q == CW'(WIDTH));

`ifdef DIV_EARLY_OUT_EN
  assign early_out = ~div_zero & (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  // Shifted partial remainder is below 2*divisor, so the low WIDTH bits of the difference are exact.
  assign shifted   = {partial_q, dividend_q[WIDTH-1]};
  assign no_borrow = (shifted >= {1'b0, divisor_q});
  assign diff      = shifted[WIDTH-1:0] - divisor_q;

  // Sign fix reads the held operands directly rather than stored sign bits.
  assign quot_fix = (op1_neg ^ op2_neg) ? -dividend_q : dividend_q;
  assign rem_fix  = op1_neg ? -partial_q : partial_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (div_zero)       state_next = S_BY_ZERO;
          else if (early_out) state_next = S_END;
          else                state_next = S_ON;
        end
      end
      S_BY_ZERO: state_next = bus.annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (bus.annul_i) state_next = S_IDLE;
        else if (done)   state_next = S_END;
      end
      S_END: begin
        if (!bus.start_i || bus.annul_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o    = (state == S_BY_ZERO) || (state == S_ON);
    bus.state_dbg = state;
    bus.result_o  = result_q;
    bus.ready_o   = ready_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      partial_q  <= '0;
      counter_q  <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q   <= 1'b0;
          result_q  <= '0;
          counter_q <= '0;
          if (accept && !div_zero) begin
            dividend_q <= mag1;
            divisor_q  <= mag2;
            partial_q  <= '0;
            if (early_out) begin
              result_q <= {bus.opdata1_i, {WIDTH{1'b0}}};
              ready_q  <= 1'b1;
            end
          end
        end
        S_BY_ZERO: begin
          result_q  <= '0;
          counter_q <= '0;
          ready_q   <= ~bus.annul_i;
        end
        S_ON: begin
          if (bus.annul_i) begin
            ready_q   <= 1'b0;
            result_q  <= '0;
            counter_q <= '0;
          end else if (!done) begin
            partial_q  <= no_borrow ? diff : shifted[WIDTH-1:0];
            dividend_q <= {dividend_q[WIDTH-2:0], no_borrow};
            counter_q  <= counter_q + CW'(1);
          end else begin
            result_q <= {rem_fix, quot_fix};
            ready_q  <= 1'b1;
          end
        end
        S_END: begin
          if (!bus.start_i || bus.annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: begin
          ready_q  <= 1'b0;
          result_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Randomised bench for div_ctrl against an arithmetic reference of DIV/DIVU results and latency.
module tb_div_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];

  div_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain language-level division with DIV/DIVU rules
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic longint magnitude(input logic sgn, input logic [31:0] v);
    longint x;
    x = sgn ? longint'($signed(v)) : longint'(v);
    return (x < 0) ? -x : x;
  endfunction

  // Ticks from raising start until ready is observed
  function automatic int ref_wait(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (magnitude(sgn, a) < magnitude(sgn, b)) return 1;
`endif
    return 34;
  endfunction

  task automatic drive_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int cycles;
    int busy_bad;
    int hold_bad;
    int exp_wait;
    logic got;
    logic [63:0] got_res;
    logic [63:0] exp_res;
    exp_q.push_back(ref_div(sgn, a, b));
    exp_wait = ref_wait(sgn, a, b);
    drive_start(sgn, a, b);
    cycles = 0;
    busy_bad = 0;
    got = 1'b0;
    while (cycles < 60 && !got) begin
      tick();
      cycles++;
      if (bus.ready_o === 1'b1) got = 1'b1;
      else if (bus.busy_o !== (exp_wait > 1)) busy_bad++;
    end
    got_res = bus.result_o;
    exp_res = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: ready not seen in %0d cycles", name, cycles);
    end else if (cycles !== exp_wait) begin
      bad++;
      $display("FAIL %s latency: got %0d ticks, expected %0d", name, cycles, exp_wait);
    end
    total++;
    if (got_res !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h expected %h", name, got_res, exp_res);
    end
    total++;
    if (busy_bad != 0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s busy: %0d wrong cycles, busy at ready=%b expected 0", name, busy_bad, bus.busy_o);
    end
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res) hold_bad++;
    end
    if (hold > 0) begin
      total++;
      if (hold_bad != 0) begin
        bad++;
        $display("FAIL %s hold: %0d cycles lost result, expected %h", name, hold_bad, exp_res);
      end
    end
    bus.start_i = 1'b0;
    tick();
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s retire: ready=%b result=%h busy=%b expected 0/0/0", name,
               bus.ready_o, bus.result_o, bus.busy_o);
    end
  endtask

  task automatic test_reset();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd0;
    bus.opdata2_i = 32'd0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b result=%h busy=%b expected 0/0/0", bus.ready_o, bus.result_o, bus.busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divu_basic();
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 2);
    run_op("divu_x_1", 1'b0, 32'hDEADBEEF, 32'd1, 0);
    run_op("divu_zero_dividend", 1'b0, 32'd0, 32'd17, 0);
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1);
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("div_m5_9", 1'b1, 32'hFFFFFFFB, 32'd9, 0);
    run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 0);
  endtask

  task automatic test_by_zero();
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 1);
    run_op("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 0);
  endtask

  task automatic test_early();
    run_op("divu_5_9", 1'b0, 32'd5, 32'd9, 1);
  endtask

  task automatic test_annul();
    int early_ready;
    early_ready = 0;
    drive_start(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (bus.ready_o !== 1'b0) early_ready++;
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    total++;
    if (early_ready != 0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_on: ready=%b busy=%b result=%h early_ready=%0d expected all 0",
               bus.ready_o, bus.busy_o, bus.result_o, early_ready);
    end
    tick();
    tick();
    run_op("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, 0);
    // Annul while the result is held retires it like a start drop
    drive_start(1'b0, 32'd77, 32'd0);
    tick();
    tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_end: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive_start(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 16; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ready=%b result=%h busy=%b expected 0/0/0",
               bus.ready_o, bus.result_o, bus.busy_o);
    end
    bus.start_i = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_op("divu_8_2_after_reset", 1'b0, 32'd8, 32'd2, 0);
  endtask

  task automatic test_random();
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 16; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = (n % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
      endcase
      run_op("random", sgn, a, b, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("b2b_b", 1'b1, 32'h7FFFFFFF, 32'h80000000, 0);
    run_op("b2b_c", 1'b0, 32'h80000000, 32'd3, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_by_zero();
    test_early();
    test_annul();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
